vldrdy2to1_join: RTL and testbench
==================================

Name: vldrdy2to1_join

Overview:
- Registered valid/ready join; counterpart of the 1-to-2 fork.
- Takes two independent input streams, each carrying a payload, and pairs the nth beat of stream 1 with the nth beat of stream 2.
- Emits each pair as one concatenated output beat.
- Sits where forked paths reconverge; per-input holding slots let the two inputs arrive with arbitrary skew without stalling each other.

Parameters:
- DW1, 8, payload width of input 1
- DW2, 8, payload width of input 2

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid_1  input  1  input 1 valid
- o_ready_1  output  1  input 1 ready
- i_data_1  input  DW1  input 1 payload
- i_valid_2  input  1  input 2 valid
- o_ready_2  output  1  input 2 ready
- i_data_2  input  DW2  input 2 payload
- o_valid  output  1  joined output valid
- i_ready  input  1  joined output ready
- o_data  output  DW1+DW2  joined payload, {slot2 data, slot1 data}; slot1 data in LSBs

Behaviour:
- Handshake: a transfer occurs on a cycle where valid & ready are both high at the rising edge.
  - Valid must not depend on ready.
  - Once o_valid is high it holds, with o_data stable, until accepted.
- State:
  - slot1: full flag s1_full plus DW1 data register.
  - slot2: full flag s2_full plus DW2 data register.
  - Output register: o_valid plus o_data register.
- Reset (async, any time including mid-transfer):
  - s1_full=0, s2_full=0, o_valid=0, o_data=0.
  - All held data is discarded.
  - o_ready_1 and o_ready_2 go high combinationally once reset is released.
  - During reset, o_ready_1 and o_ready_2 are forced to 0.
- fire = s1_full & s2_full & (~o_valid | i_ready).
- Ready rules:
  - o_ready_1 = ~i_rst & (~s1_full | fire).
  - o_ready_2 = ~i_rst & (~s2_full | fire).
  - There is a combinational path i_ready -> o_ready_x through fire. This is intended: it gives full throughput.
- Slot update, per slot x:
  - Input accept: s_x_full <= 1 and data captured.
  - fire without accept: s_x_full <= 0.
  - fire with accept on the same cycle: the slot stays full with the new data.
- Output update:
  - fire: o_valid <= 1, o_data <= {slot2, slot1}.
  - Else if o_valid & i_ready: o_valid <= 0.
  - Else: hold.
- Latency:
  - Both inputs accepted in cycle N -> o_valid high in cycle N+2.
  - Skewed inputs: output appears 2 cycles after the later input is accepted.
- Throughput: one beat per cycle in steady state when both inputs stream and i_ready=1.
- Ordering: strict FIFO pairing. Beat k of input 1 is always paired with beat k of input 2. No beat is dropped or duplicated.
- Skew limit: at most one unpaired beat per side is buffered. A side with a full slot stalls (ready=0) until the other side catches up and fire occurs.
- Output backpressure: i_ready=0 with o_valid=1 and both slots full -> fire=0, so both input readies drop. Nothing is overwritten.

Decomposition:
- No package types are needed. Parameters are local to the module.
- One natural sub-module: vldrdy_slot, a 1-entry holding register with full flag.
  - Parameter: DW.
  - Ports: i_clk, i_rst, i_valid, o_ready, i_data, i_pop, o_full, o_data.
  - Instantiated twice.
- The output register stays in the top module.

Test Plan:
- Reset: assert i_rst mid-stream with both slots full and o_valid=1 -> same cycle o_valid=0, o_ready_1=o_ready_2=0; after release, readies are 1 and no stale pair is emitted.
- Aligned single beat: cycle 0 i_data_1=8'hA5, i_data_2=8'h3C, both valid, i_ready=1 -> cycle 2 o_valid=1, o_data=16'h3CA5 for exactly one cycle.
- Skew:
  - Stimulus: input 1 sends 8'h11 at cycle 0 and offers 8'h22 from cycle 1; input 2 sends 8'hE1 at cycle 5.
  - Required: o_ready_1=0 during cycles 1-5; o_data=16'hE111 at cycle 7; 8'h22 is accepted at cycle 6 and waits for its partner.
- Backpressure: stream 4 aligned pairs with i_ready=0 for cycles 3-6 -> o_data holds stable, input readies drop, all 4 pairs arrive in order with none lost.
- Full throughput: 16 aligned beats with values 0..15 on both sides, i_ready=1 -> 16 consecutive o_valid cycles, o_data={k,k}, no bubbles.
- Random: random valids and random i_ready over 10k cycles -> a scoreboard confirms in-order pairing and that valid and data stay stable while stalled.

Source files
------------

// File: rtl/vldrdy2to1_join_pkg.sv
// vldrdy2to1_join_pkg: shared defaults for the 2-to-1 valid/ready join.
package vldrdy2to1_join_pkg;
    localparam int DW1_DEF = 8;
    localparam int DW2_DEF = 8;
endpackage

// File: rtl/vldrdy2to1_join_if.sv
// vldrdy2to1_join_if: two input streams and one joined output stream.
interface vldrdy2to1_join_if #(
    parameter int DW1 = vldrdy2to1_join_pkg::DW1_DEF,
    parameter int DW2 = vldrdy2to1_join_pkg::DW2_DEF
);
    logic               i_valid_1;
    logic               o_ready_1;
    logic [DW1-1:0]     i_data_1;
    logic               i_valid_2;
    logic               o_ready_2;
    logic [DW2-1:0]     i_data_2;
    logic               o_valid;
    logic               i_ready;
    logic [DW1+DW2-1:0] o_data;

    modport slave (
        input  i_valid_1, i_data_1, i_valid_2, i_data_2, i_ready,
        output o_ready_1, o_ready_2, o_valid, o_data
    );
    modport master (
        output i_valid_1, i_data_1, i_valid_2, i_data_2, i_ready,
        input  o_ready_1, o_ready_2, o_valid, o_data
    );
endinterface

// File: rtl/vldrdy_slot.sv
// vldrdy_slot: one-entry holding register; a pop on the same cycle as an accept refills it.
module vldrdy_slot #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic [DW-1:0] o_data
);
    logic          full_q, full_d, accept;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        o_ready = ~i_rst & (~full_q | i_pop);
        accept  = i_valid & o_ready;
        full_d  = accept ? 1'b1 : (i_pop ? 1'b0 : full_q);
        data_d  = accept ? i_data : data_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign o_full = full_q;
    assign o_data = data_q;
endmodule

// File: rtl/vldrdy2to1_join.sv
// vldrdy2to1_join: pairs beat n of each input into one registered {data_2, data_1} output beat.
module vldrdy2to1_join #(
    parameter int DW1 = vldrdy2to1_join_pkg::DW1_DEF,
    parameter int DW2 = vldrdy2to1_join_pkg::DW2_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    vldrdy2to1_join_if.slave        bus
);
    logic                   s1_full, s2_full, fire;
    logic [DW1-1:0]         s1_data;
    logic [DW2-1:0]         s2_data;
    logic                   o_valid_q, o_valid_d;
    logic [DW1+DW2-1:0]     o_data_q, o_data_d;

    vldrdy_slot #(.DW(DW1)) u_slot1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (bus.i_valid_1),
        .o_ready (bus.o_ready_1),
        .i_data  (bus.i_data_1),
        .i_pop   (fire),
        .o_full  (s1_full),
        .o_data  (s1_data)
    );

    vldrdy_slot #(.DW(DW2)) u_slot2 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (bus.i_valid_2),
        .o_ready (bus.o_ready_2),
        .i_data  (bus.i_data_2),
        .i_pop   (fire),
        .o_full  (s2_full),
        .o_data  (s2_data)
    );

    // i_ready feeds fire, and so the input readies, combinationally for full throughput
    always_comb begin
        fire      = s1_full & s2_full & (~o_valid_q | bus.i_ready);
        o_valid_d = fire | (o_valid_q & ~bus.i_ready);
        o_data_d  = fire ? {s2_data, s1_data} : o_data_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
endmodule

// File: tb/tb_vldrdy2to1_join.sv
// tb_vldrdy2to1_join: directed vector table plus stream sequences with an in-order pair scoreboard.
module tb_vldrdy2to1_join;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vldrdy2to1_join_if #(.DW1(8), .DW2(8)) bus ();

    vldrdy2to1_join #(.DW1(8), .DW2(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v1;
        logic [7:0] d1;
        logic       v2;
        logic [7:0] d2;
        logic       rdy;
        logic       er1;
        logic       er2;
        logic       eov;
        logic [15:0] eod;
    } vec_t;

    vec_t       tbl [16];
    logic [7:0] src1 [4096];
    logic [7:0] src2 [4096];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v1, input logic [7:0] d1, input logic v2, input logic [7:0] d2, input logic rdy);
        bus.i_valid_1 = v1;
        bus.i_data_1  = d1;
        bus.i_valid_2 = v2;
        bus.i_data_2  = d2;
        bus.i_ready   = rdy;
    endtask

    // mode 0: throughput, 1: backpressure cycles 3-6, 2: random valids and ready
    task automatic run(input int n, input int mode, input int max_cyc);
        int          i1 = 0, i2 = 0, k = 0, cyc = 0, first = -1, last = -1, nov = 0;
        logic        pstall = 1'b0;
        logic [15:0] pod = '0;
        logic        v1, v2, rdy, r1, r2, ov;
        logic [15:0] od;
        for (int j = 0; j < n; j++) begin
            src1[j] = (mode == 0) ? 8'(j) : (mode == 1) ? 8'(8'h40 + j) : 8'($urandom);
            src2[j] = (mode == 0) ? 8'(j) : (mode == 1) ? 8'(8'h80 + j) : 8'($urandom);
        end
        while (k < n && cyc < max_cyc) begin
            v1  = (i1 < n) && (mode != 2 || $urandom_range(1, 0) == 1);
            v2  = (i2 < n) && (mode != 2 || $urandom_range(1, 0) == 1);
            rdy = (mode == 1) ? !(cyc >= 3 && cyc <= 6) : (mode == 2) ? ($urandom_range(3, 0) != 0) : 1'b1;
            drive(v1, src1[i1], v2, src2[i2], rdy);
            @(negedge clk);
            r1 = bus.o_ready_1;
            r2 = bus.o_ready_2;
            ov = bus.o_valid;
            od = bus.o_data;
            if (pstall) begin
                chk("stall_valid", 32'(ov), 32'd1);
                chk("stall_data", 32'(od), 32'(pod));
            end
            if (mode == 1 && cyc == 3) begin
                chk("bp_ready_1", 32'(r1), 32'd0);
                chk("bp_ready_2", 32'(r2), 32'd0);
            end
            if (ov) nov++;
            if (ov && rdy) begin
                chk("pair", 32'(od), 32'({src2[k], src1[k]}));
                if (first < 0) first = cyc;
                last = cyc;
                k++;
            end
            if (v1 && r1) i1++;
            if (v2 && r2) i2++;
            pstall = ov && !rdy;
            pod    = od;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("beats", 32'(k), 32'(n));
        if (mode == 0) begin
            chk("bubbles", 32'(last - first), 32'd15);
            chk("ov_cycles", 32'(nov), 32'd16);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_valid", 32'(bus.o_valid), 32'd0);
        chk("drain_ready", 32'({bus.o_ready_2, bus.o_ready_1}), 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h3CA5};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3CA5};
        tbl[4]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3CA5};
        tbl[5]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3CA5};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3CA5};
        tbl[7]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3CA5};
        tbl[8]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3CA5};
        tbl[9]  = '{1'b1, 8'h22, 1'b1, 8'hE1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3CA5};
        tbl[10] = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h3CA5};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'hE111};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 8'hF2, 1'b1, 1'b0, 1'b1, 1'b0, 16'hE111};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'hE111};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'hF222};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'hF222};

        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1;
        chk("rst_ready", 32'({bus.o_ready_2, bus.o_ready_1}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_ready_1", i), 32'(bus.o_ready_1), 32'(tbl[i].er1));
            chk($sformatf("vec%0d_ready_2", i), 32'(bus.o_ready_2), 32'(tbl[i].er2));
            chk($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].eov));
            chk($sformatf("vec%0d_data", i), 32'(bus.o_data), 32'(tbl[i].eod));
            @(posedge clk);
            #1;
        end

        // fill output register and both slots under backpressure, then reset mid-stream
        drive(1'b1, 8'h55, 1'b1, 8'h66, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        chk("pre_rst_data", 32'(bus.o_data), 32'h6655);
        chk("pre_rst_ready", 32'({bus.o_ready_2, bus.o_ready_1}), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("async_rst_data", 32'(bus.o_data), 32'h0000);
        chk("async_rst_ready", 32'({bus.o_ready_2, bus.o_ready_1}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'({bus.o_ready_2, bus.o_ready_1}), 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("no_stale_%0d", i), 32'(bus.o_valid), 32'd0);
        end
        @(posedge clk); #1;

        run(4, 1, 100);
        run(16, 0, 100);
        run(2500, 2, 10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
